// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter.
// One input bit per clock; results are registered and held between runs.
module bin_to_bcd_seq #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            digit_count
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [IN_W-1:0]       shift_q;
  logic [4*DIGITS-1:0]   scr_q;
  logic [CW-1:0]         cnt_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [3:0]            dcnt_q;
  logic                  done_q;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   shifted;
  logic [3:0]            ndig;
  logic                  last;
  logic                  accept;

  assign last   = (state_q == SHIFT) && (cnt_q == CW'(1));
  // A start seen on the finishing edge chains straight into the next run
  assign accept = start && ((state_q == IDLE) || last);

  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[4*DIGITS-2:0], shift_q[IN_W-1]};

  always_comb begin
    ndig = 4'd1;
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted[4*k +: 4] != 4'd0)
        ndig = 4'(k + 1);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: if (last && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      dcnt_q  <= 4'd1;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (last) begin
        bcd_q  <= shifted;
        dcnt_q <= ndig;
      end
      if (accept) begin
        shift_q <= bin_in;
        scr_q   <= '0;
        cnt_q   <= CW'(IN_W);
      end else if (state_q == SHIFT) begin
        shift_q <= shift_q << 1;
        scr_q   <= shifted;
        cnt_q   <= cnt_q - CW'(1);
      end
    end
  end

  assign done        = done_q;
  assign bcd_out     = bcd_q;
  assign digit_count = dcnt_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;
  logic [3:0]  digit_count;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  cnt;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   mon_busy = 0;
  int   busy_gaps = 0;

  bin_to_bcd_seq dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .start(start),
    .bin_in(bin_in),
    .busy(busy),
    .done(done),
    .bcd_out(bcd_out),
    .digit_count(digit_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [39:0] ref_bcd(input longint unsigned v);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_cnt(input longint unsigned v);
    int c;
    c = 0;
    if (v == 0) return 4'd1;
    while (v != 0) begin
      c++;
      v = v / 10;
    end
    return 4'(c);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_t e;
    e.bcd = ref_bcd(longint'(v));
    e.cnt = ref_cnt(longint'(v));
    e.due = cyc + 32;
    q.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (mon_busy && !busy) busy_gaps++;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
        chk("digit_count", 64'(digit_count), 64'(e.cnt));
        chk("done_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
    else if (q.size() != 0) chk("pending_results", 64'(q.size()), 64'd0);
  endtask

  task automatic single_conv(input logic [31:0] v);
    int t;
    int n;
    bit seen;
    t = 0;
    n = 0;
    seen = 0;
    @(posedge sys_clk);
    #1;
    bin_in = v;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    push(v);
    while (!seen && t < 100) begin
      @(negedge sys_clk);
      t++;
      if (done) seen = 1;
      else if (busy) n++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_len", 64'(n), 64'd32);
  endtask

  task automatic stream(input logic [31:0] vals[$]);
    @(posedge sys_clk);
    #1;
    start = 1'b1;
    busy_gaps = 0;
    foreach (vals[i]) begin
      bin_in = vals[i];
      @(posedge sys_clk);
      #1;
      push(vals[i]);
      mon_busy = 1;
      if (i != vals.size() - 1) repeat (31) @(posedge sys_clk);
      #1;
    end
    start = 1'b0;
    mon_busy = 0;
    chk("busy_gap", 64'(busy_gaps), 64'd0);
  endtask

  initial begin
    logic [31:0] v[$];
    int          hold_bad;

    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_cnt", 64'(digit_count), 64'd1);
    rst = 1'b0;
    hold_bad = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 40'd0 ||
          digit_count !== 4'd1) hold_bad++;
    end
    chk("idle_hold", 64'(hold_bad), 64'd0);

    single_conv(32'd0);
    single_conv(32'd9);
    single_conv(32'd10);
    single_conv(32'd1234);
    single_conv(32'd4294967295);
    drain();

    // start pulses during a conversion must be ignored
    @(posedge sys_clk);
    #1;
    bin_in = 32'd5678;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    push(32'd5678);
    repeat (4) @(posedge sys_clk);
    #1;
    bin_in = 32'd1111;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge sys_clk);
    #1;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    drain();
    repeat (40) @(negedge sys_clk);

    v = '{32'd42, 32'd99999, 32'd7};
    stream(v);
    drain();

    v.delete();
    v.push_back(32'd999999999);
    v.push_back(32'd1000000000);
    v.push_back(32'd4000000000);
    v.push_back(32'd5);
    for (int i = 0; i < 200; i++) v.push_back($urandom);
    for (int i = 0; i < 40; i++) v.push_back($urandom_range(0, 99999));
    stream(v);
    drain();

    // reset in the middle of a conversion discards it
    @(posedge sys_clk);
    #1;
    bin_in = 32'd123456;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge sys_clk);
    #1;
    rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_bcd", 64'(bcd_out), 64'd0);
    chk("mid_rst_cnt", 64'(digit_count), 64'd1);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge sys_clk);
    chk("mid_rst_bcd_hold", 64'(bcd_out), 64'd0);
    single_conv(32'd8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
